// File: rtl/muldiv_pkg.sv
// Shared encodings and the sign helper for the iterative multiply/divide unit.
package muldiv_pkg;

   typedef enum logic [1:0] {
      OP_MULTU = 2'b00,
      OP_MULT  = 2'b01,
      OP_DIVU  = 2'b10,
      OP_DIV   = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIN  = 2'b10
   } state_e;

   // Widest value the helper handles; callers cast the result back to their width.
   localparam int unsigned MAX_W = 128;

   function automatic logic [MAX_W-1:0] cond_neg(input logic [MAX_W-1:0] v, input logic en);
      return en ? (~v + MAX_W'(1)) : v;
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration datapath: W-bit add, or subtract via inverted operand plus carry-in.
module muldiv_step #(
   parameter int unsigned W = 33
) (
   input  logic [W-1:0] x_i,
   input  logic [W-1:0] y_i,
   input  logic         sub_i,
   output logic [W-1:0] sum_o
);

   logic [W-1:0] y_eff;

   assign y_eff = sub_i ? ~y_i : y_i;
   assign sum_o = x_i + y_eff + W'(sub_i);

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers, N iterations per operation.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned N = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [1:0]   op,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] hi,
   output logic [N-1:0] lo,
   output logic         div_by_zero
);

   localparam int unsigned CW = $clog2(N) + 1;

   // Handshake: start is taken on a rising edge only while busy=0; busy stays high until
   // the edge that writes hi/lo, and done is high for exactly the cycle after that edge.
   state_e         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [2*N-1:0] acc_q, acc_d;
   logic [N-1:0]   mop_q, mop_d;
   logic           is_div_q, is_div_d;
   logic           dz_q, dz_d;
   logic           neg_lo_q, neg_lo_d;
   logic           neg_hi_q, neg_hi_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic [N-1:0]   hi_q, hi_d;
   logic [N-1:0]   lo_q, lo_d;
   logic           dbz_q, dbz_d;

   logic           op_signed, op_div, a_neg, b_neg;
   logic [N-1:0]   a_mag, b_mag;
   logic [N:0]     step_x, step_sum;
   logic [2*N-1:0] prod_fix;
   logic [N-1:0]   quo_fix, rem_fix;

   assign op_signed = (op == OP_MULT) || (op == OP_DIV);
   assign op_div    = (op == OP_DIVU) || (op == OP_DIV);
   assign a_neg     = op_signed & a[N-1];
   assign b_neg     = op_signed & b[N-1];
   assign a_mag     = N'(cond_neg(MAX_W'(a), a_neg));
   assign b_mag     = N'(cond_neg(MAX_W'(b), b_neg));

   // Divide shifts the next dividend bit into the partial remainder before the trial subtract.
   assign step_x = is_div_q ? {acc_q[2*N-1:N], acc_q[N-1]} : {1'b0, acc_q[2*N-1:N]};

   muldiv_step #(.W(N + 1)) u_step (
      .x_i   (step_x),
      .y_i   ({1'b0, mop_q}),
      .sub_i (is_div_q),
      .sum_o (step_sum)
   );

   assign prod_fix = (2*N)'(cond_neg(MAX_W'(acc_q), neg_lo_q));
   assign quo_fix  = N'(cond_neg(MAX_W'(acc_q[N-1:0]), neg_lo_q));
   assign rem_fix  = N'(cond_neg(MAX_W'(acc_q[2*N-1:N]), neg_hi_q));

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      mop_d    = mop_q;
      is_div_d = is_div_q;
      dz_d     = dz_q;
      neg_lo_d = neg_lo_q;
      neg_hi_d = neg_hi_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      hi_d     = hi_q;
      lo_d     = lo_q;
      dbz_d    = dbz_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               is_div_d = op_div;
               neg_lo_d = a_neg ^ b_neg;
               neg_hi_d = a_neg;
               busy_d   = 1'b1;
               cnt_d    = '0;
               dz_d     = 1'b0;
               state_d  = CALC;
               if (op_div) begin
                  mop_d = b_mag;
                  acc_d = {{N{1'b0}}, a_mag};
                  if (b == '0) begin
                     dz_d    = 1'b1;
                     acc_d   = {a, {N{1'b1}}};
                     state_d = FIN;
                  end
               end else begin
                  mop_d = a_mag;
                  acc_d = {{N{1'b0}}, b_mag};
               end
            end
         end
         CALC: begin
            if (is_div_q) begin
               // A clear top bit means the trial subtract did not borrow.
               if (!step_sum[N]) acc_d = {step_sum[N-1:0], acc_q[N-2:0], 1'b1};
               else              acc_d = {acc_q[2*N-2:0], 1'b0};
            end else begin
               if (acc_q[0]) acc_d = {step_sum, acc_q[N-1:1]};
               else          acc_d = {1'b0, acc_q[2*N-1:N], acc_q[N-1:1]};
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(N - 1)) state_d = FIN;
         end
         FIN: begin
            if (dz_q) begin
               hi_d  = acc_q[2*N-1:N];
               lo_d  = acc_q[N-1:0];
               dbz_d = 1'b1;
            end else if (is_div_q) begin
               hi_d  = rem_fix;
               lo_d  = quo_fix;
               dbz_d = 1'b0;
            end else begin
               hi_d  = prod_fix[2*N-1:N];
               lo_d  = prod_fix[N-1:0];
               dbz_d = 1'b0;
            end
            dz_d    = 1'b0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         mop_q    <= '0;
         is_div_q <= 1'b0;
         dz_q     <= 1'b0;
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         dbz_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         mop_q    <= mop_d;
         is_div_q <= is_div_d;
         dz_q     <= dz_d;
         neg_lo_q <= neg_lo_d;
         neg_hi_q <= neg_hi_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         dbz_q    <= dbz_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign hi          = hi_q;
   assign lo          = lo_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

   localparam int N = 32;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [1:0]   op;
   logic [N-1:0] a, b;
   logic         busy, done, div_by_zero;
   logic [N-1:0] hi, lo;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   muldiv_unit #(.N(N)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .op          (op),
      .a           (a),
      .b           (b),
      .busy        (busy),
      .done        (done),
      .hi          (hi),
      .lo          (lo),
      .div_by_zero (div_by_zero)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: {div_by_zero, hi, lo} from plain integer arithmetic.
   function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      longint      sx, sy;
      logic [63:0] p;
      logic [31:0] q, r;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      if (o == 2'b00) begin
         p = {32'b0, x} * {32'b0, y};
         return {1'b0, p};
      end
      if (o == 2'b01) begin
         p = 64'(sx * sy);
         return {1'b0, p};
      end
      if (y == 32'd0) return {1'b1, x, 32'hFFFF_FFFF};
      if (o == 2'b10) begin
         q = x / y;
         r = x % y;
      end else begin
         q = 32'(sx / sy);
         r = 32'(sx % sy);
      end
      return {1'b0, r, q};
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return 32'd1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input string tag);
      logic [64:0] e;
      int          cyc;
      int          lat;
      e   = model(o, x, y);
      lat = e[64] ? 1 : N + 1;
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk); #1;
      start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
      chk({tag, "_busy_set"}, 64'(busy), 64'd1);
      cyc = 0;
      while (done !== 1'b1 && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk({tag, "_latency"}, 64'(cyc), 64'(lat));
      chk({tag, "_hi"}, 64'(hi), 64'(e[63:32]));
      chk({tag, "_lo"}, 64'(lo), 64'(e[31:0]));
      chk({tag, "_dbz"}, 64'(div_by_zero), 64'(e[64]));
      chk({tag, "_busy_clr"}, 64'(busy), 64'd0);
   endtask

   initial begin
      int          cyc;
      logic        saw_done;
      logic [1:0]  ro;
      logic [31:0] ra, rb;

      reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_hi", 64'(hi), 64'd0);
      chk("rst_lo", 64'(lo), 64'd0);
      chk("rst_dbz", 64'(div_by_zero), 64'd0);
      @(negedge clk);
      reset = 1'b0;

      // Consecutive calls start on the done cycle, so these also cover back-to-back acceptance.
      do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
      do_op(2'b01, 32'hFFFF_FFFD, 32'd7, "mult_neg");
      do_op(2'b01, 32'h8000_0000, 32'h8000_0000, "mult_min");
      do_op(2'b10, 32'd100, 32'd7, "divu");
      do_op(2'b11, 32'hFFFF_FFF9, 32'd2, "div_neg");
      do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, "div_wrap");
      do_op(2'b10, 32'd5, 32'd0, "divu_zero");
      do_op(2'b00, 32'd2, 32'd3, "multu_clr");
      do_op(2'b11, 32'hFFFF_FFF0, 32'd0, "div_zero");
      do_op(2'b11, 32'd7, 32'hFFFF_FFFE, "div_pos_neg");

      // A second start during the calculation must be dropped.
      @(negedge clk);
      start = 1'b1; op = 2'b00; a = 32'd2; b = 32'd3;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      start = 1'b1; op = 2'b10; a = 32'd9; b = 32'd3;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 6;
      while (done !== 1'b1 && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("ignore_latency", 64'(cyc), 64'(N + 1));
      chk("ignore_lo", 64'(lo), 64'd6);
      chk("ignore_hi", 64'(hi), 64'd0);
      @(posedge clk); #1;
      chk("ignore_no_restart", 64'(busy), 64'd0);

      // Reset in the middle of a divide aborts it with no completion pulse.
      do_op(2'b00, 32'd11, 32'd13, "pre_abort");
      @(negedge clk);
      start = 1'b1; op = 2'b11; a = 32'hFFFF_FF00; b = 32'd3;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_hi", 64'(hi), 64'd0);
      chk("abort_lo", 64'(lo), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      saw_done = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done !== 1'b0) saw_done = 1'b1;
      end
      chk("abort_no_done", 64'(saw_done), 64'd0);

      for (int i = 0; i < 40; i++) begin
         ro = 2'($urandom_range(0, 3));
         ra = pick();
         rb = ($urandom_range(0, 5) == 0) ? 32'd0 : pick();
         do_op(ro, ra, rb, $sformatf("rand%0d", i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
